// File: rtl/keypad_pkg.sv
// keypad_pkg: row-drive patterns, key codes, {row,col}->code map and paddle key positions.
package keypad_pkg;
    typedef enum logic {SETTLE, SAMPLE} scan_state_t;
    localparam int DB_CNT_W = 3;
    localparam logic [3:0] ROW0 = 4'b1110;
    localparam logic [3:0] ROW1 = 4'b1101;
    localparam logic [3:0] ROW2 = 4'b1011;
    localparam logic [3:0] ROW3 = 4'b0111;
    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;
    // Entry i = row*4+col occupies bits [4i+3:4i]; listed from entry 15 down to 0.
    localparam logic [63:0] KEY_MAP = {KEY_C, KEY_D, KEY_E, KEY_F,
                                       KEY_B, KEY_3, KEY_6, KEY_9,
                                       KEY_A, KEY_2, KEY_5, KEY_8,
                                       KEY_0, KEY_1, KEY_4, KEY_7};
    localparam int PAD_UP1   = 7;
    localparam int PAD_DOWN1 = 3;
    localparam int PAD_UP2   = 4;
    localparam int PAD_DOWN2 = 0;

    function automatic logic [3:0] key_code_of(input logic [3:0] idx);
        return KEY_MAP[{idx, 2'b00} +: 4];
    endfunction
endpackage

// File: rtl/kp_debounce.sv
// kp_debounce: one key's debounced state and disagreement counter, advanced only on its row's sample.
module kp_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic pressed,
    output logic state,
    output logic rise,
    output logic fall
);
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_SCANS - 1);

    logic [DB_CNT_W-1:0] cnt;
    logic                flip;

    assign flip = sample_en && (pressed != state) && (cnt == CNT_LAST);
    assign rise = flip & pressed;
    assign fall = flip & ~pressed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= 1'b0;
            cnt   <= '0;
        end else if (sample_en) begin
            state <= state ^ flip;
            cnt   <= (pressed == state || flip) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/keypad_scan_sequencer.sv
// keypad_scan_sequencer: 4x4 keypad row scanner with per-key debounce, paddle levels
// and a single-key press event per sample.
module keypad_scan_sequencer
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] kp_col,
    output logic [3:0] kp_row,
    output logic       up1,
    output logic       down1,
    output logic       up2,
    output logic       down2,
    output logic       key_valid,
    output logic [3:0] key_code
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    scan_state_t state, state_nx;
    logic [3:0]  cnt, cnt_nx, row_nx, code_nx;
    logic [3:0]  col_meta, col_sync;
    logic [1:0]  row_idx;
    logic [15:0] deb, rise, fall, deb_nx, press;

    always_comb begin
        row_idx  = (kp_row == ROW0) ? 2'd0 : (kp_row == ROW1) ? 2'd1 : (kp_row == ROW2) ? 2'd2 : 2'd3;
        row_nx   = kp_row;
        state_nx = state;
        cnt_nx   = cnt + 4'd1;
        if (state == SETTLE) begin
            if (cnt == SETTLE_LAST) begin
                state_nx = SAMPLE;
                cnt_nx   = '0;
            end
        end else begin
            state_nx = SETTLE;
            cnt_nx   = '0;
            // An illegal drive pattern falls back to ROW0 so the scan self-recovers.
            row_nx   = (kp_row == ROW0) ? ROW1 : (kp_row == ROW1) ? ROW2 : (kp_row == ROW2) ? ROW3 : ROW0;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_key
        kp_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_db (
            .clk      (clk),
            .rst      (rst),
            .sample_en(state == SAMPLE && row_idx == 2'(g / 4)),
            .pressed  (~col_sync[g % 4]),
            .state    (deb[g]),
            .rise     (rise[g]),
            .fall     (fall[g])
        );
    end

    // Descending scan leaves the lowest-index new press as the reported code.
    always_comb begin
        deb_nx  = (deb | rise) & ~fall;
        press   = deb_nx & ~deb;
        code_nx = key_code;
        for (int i = 15; i >= 0; i--)
            if (press[i]) code_nx = key_code_of(4'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SETTLE;
            cnt       <= '0;
            kp_row    <= ROW0;
            col_meta  <= '1;
            col_sync  <= '1;
            up1       <= 1'b0;
            down1     <= 1'b0;
            up2       <= 1'b0;
            down2     <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            kp_row    <= row_nx;
            col_meta  <= kp_col;
            col_sync  <= col_meta;
            up1       <= deb_nx[PAD_UP1] & ~deb_nx[PAD_DOWN1];
            down1     <= deb_nx[PAD_DOWN1] & ~deb_nx[PAD_UP1];
            up2       <= deb_nx[PAD_UP2] & ~deb_nx[PAD_DOWN2];
            down2     <= deb_nx[PAD_DOWN2] & ~deb_nx[PAD_UP2];
            key_valid <= |press;
            key_code  <= code_nx;
        end
    end
endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// tb_keypad_scan_sequencer: frame-stepped directed vectors against a behavioural keypad matrix.
module tb_keypad_scan_sequencer;
    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic [3:0]  pad;
        int          events;
        logic [3:0]  code;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] kp_col, kp_row, key_code;
    logic       up1, down1, up2, down2, key_valid;
    logic [15:0] keys = '0;
    logic       force_low = 1'b1;
    int         checks = 0, errors = 0, ev_cnt = 0, kv_double = 0, e0;
    logic       prev_kv = 1'b0;
    vec_t       vecs[19];

    keypad_scan_sequencer dut (
        .clk(clk), .rst(rst), .kp_col(kp_col), .kp_row(kp_row),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2),
        .key_valid(key_valid), .key_code(key_code)
    );

    always #5 clk = ~clk;

    // Key index = row*4+col; a held key pulls its column low while its row is driven.
    always_comb begin
        kp_col = 4'b1111;
        for (int r = 0; r < 4; r++)
            if (kp_row[r] == 1'b0)
                for (int c = 0; c < 4; c++)
                    if (keys[r*4+c]) kp_col[c] = 1'b0;
        if (force_low) kp_col = 4'b0000;
    end

    always @(posedge clk) begin
        #1;
        if (key_valid) begin
            ev_cnt++;
            if (prev_kv) kv_double++;
        end
        prev_kv = key_valid;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n * 12) @(posedge clk);
        #2;
    endtask

    initial begin
        // {keys, frames, {up1,down1,up2,down2}, key_valid pulses, key_code afterwards}
        vecs[0]  = '{16'h0080, 1, 4'b0000, 0, 4'h0};
        vecs[1]  = '{16'h0080, 1, 4'b1000, 1, 4'hA};
        vecs[2]  = '{16'h0000, 1, 4'b1000, 0, 4'hA};
        vecs[3]  = '{16'h0000, 1, 4'b0000, 0, 4'hA};
        vecs[4]  = '{16'h0008, 1, 4'b0000, 0, 4'hA};
        vecs[5]  = '{16'h0000, 1, 4'b0000, 0, 4'hA};
        vecs[6]  = '{16'h0008, 1, 4'b0000, 0, 4'hA};
        vecs[7]  = '{16'h0000, 1, 4'b0000, 0, 4'hA};
        vecs[8]  = '{16'h0011, 2, 4'b0000, 2, 4'h8};
        vecs[9]  = '{16'h0010, 1, 4'b0000, 0, 4'h8};
        vecs[10] = '{16'h0010, 1, 4'b0010, 0, 4'h8};
        vecs[11] = '{16'h0000, 2, 4'b0000, 0, 4'h8};
        vecs[12] = '{16'h0009, 2, 4'b0101, 1, 4'h7};
        vecs[13] = '{16'h0000, 2, 4'b0000, 0, 4'h7};
        vecs[14] = '{16'h0060, 2, 4'b0000, 1, 4'h5};
        vecs[15] = '{16'h9000, 2, 4'b0000, 1, 4'hF};
        vecs[16] = '{16'h0000, 2, 4'b0000, 0, 4'hF};
        vecs[17] = '{16'h0088, 2, 4'b0000, 2, 4'hA};
        vecs[18] = '{16'h0000, 2, 4'b0000, 0, 4'hA};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_row", 16'(kp_row), 16'h000E);
        chk("rst_pad", 16'({up1, down1, up2, down2}), 16'h0);
        chk("rst_kv", 16'(key_valid), 16'h0);
        chk("rst_code", 16'(key_code), 16'h0);
        force_low = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk); #2;
        chk("row_hold", 16'(kp_row), 16'h000E);
        @(posedge clk); #2;
        chk("row_step1", 16'(kp_row), 16'h000D);
        repeat (3) @(posedge clk); #2;
        chk("row_step2", 16'(kp_row), 16'h000B);
        repeat (3) @(posedge clk); #2;
        chk("row_step3", 16'(kp_row), 16'h0007);
        repeat (3) @(posedge clk); #2;
        chk("row_wrap", 16'(kp_row), 16'h000E);

        for (int i = 0; i < 19; i++) begin
            keys = vecs[i].keys;
            e0 = ev_cnt;
            run_frames(vecs[i].frames);
            chk($sformatf("v%0d_pad", i), 16'({up1, down1, up2, down2}), 16'(vecs[i].pad));
            chk($sformatf("v%0d_events", i), 16'(ev_cnt - e0), 16'(vecs[i].events));
            chk($sformatf("v%0d_code", i), 16'(key_code), 16'(vecs[i].code));
        end

        keys = 16'h0080;
        run_frames(2);
        chk("pre_rst_up1", 16'(up1), 16'h1);
        repeat (7) @(posedge clk); #2;
        chk("mid_row", 16'(kp_row), 16'h000B);
        rst = 1'b0;
        #1;
        chk("async_row", 16'(kp_row), 16'h000E);
        chk("async_up1", 16'(up1), 16'h0);
        chk("async_code", 16'(key_code), 16'h0);
        repeat (2) @(posedge clk); #2;
        rst = 1'b1;
        e0 = ev_cnt;
        run_frames(1);
        chk("post_rst_f1_up1", 16'(up1), 16'h0);
        chk("post_rst_f1_events", 16'(ev_cnt - e0), 16'h0);
        run_frames(1);
        chk("post_rst_f2_up1", 16'(up1), 16'h1);
        chk("post_rst_f2_events", 16'(ev_cnt - e0), 16'h1);
        chk("post_rst_code", 16'(key_code), 16'hA);
        chk("kv_single", 16'(kv_double), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan_sequencer.md
# keypad_scan_sequencer

Row-scanning sequencer for the 4x4 game keypad. It drives one keypad row low at a time and samples the columns after a settle delay. It debounces all 16 keys and produces the four paddle command levels (up1/down1/up2/down2) plus a one-cycle key-press event. It sits between the keypad pins and the paddle/game logic, and owns the row drive exclusively.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles each row is driven before its columns are sampled; legal range 2..15; covers the 2-flop column synchronizer.
- DEBOUNCE_SCANS, 2, consecutive differing samples (one per frame) needed to flip a key's debounced state; legal range 1..7.

Ports:
- clk  input  1  scan clock (100 Hz in the game build)
- rst  input  1  asynchronous, active-low reset
- kp_col  input  4  column sense, active-low (0 = key in driven row pressed); asynchronous to clk
- kp_row  output  4  row drive, one-hot active-low
- up1  output  1  player 1 up (key A held, debounced)
- down1  output  1  player 1 down (key 0 held, debounced)
- up2  output  1  player 2 up (key 8 held, debounced)
- down2  output  1  player 2 down (key 7 held, debounced)
- key_valid  output  1  one-cycle pulse on a debounced press
- key_code  output  4  code of the reported key; valid with key_valid, holds last value otherwise

## Operation
- Key map, as {row, col}:
  - Row 1110: cols 1110/1101/1011/0111 = 7/4/1/0.
  - Row 1101: 8/5/2/A.
  - Row 1011: 9/6/3/B.
  - Row 0111: F/E/D/C.
- kp_col passes through a 2-flop synchronizer before any use.
- FSM states:
  - SETTLE: counter runs 0..SETTLE_CYCLES-1. At the last count, go to SAMPLE.
  - SAMPLE: one cycle. Update the 4 keys of the current row, rotate kp_row left (1110→1101→1011→0111→1110), clear the counter, return to SETTLE.
- Frame length = 4*(SETTLE_CYCLES+1) cycles; default 12.
- Per-key debounce:
  - Sample pressed = synced col bit low.
  - If the sample equals the debounced state, clear the counter.
  - Otherwise increment the counter. On reaching DEBOUNCE_SCANS, flip the debounced state and clear the counter.
  - Keys only update in their own row's SAMPLE cycle.
- Press event: on a SAMPLE cycle where one or more keys of that row flip released→pressed, pulse key_valid and set key_code.
  - If several keys flip in the same sample, report the lowest column index (col bit 0 first).
  - Other keys' debounced states still update, but those presses are not reported.
  - Releases never generate events.
- Paddle outputs:
  - up1 = deb[A] & ~deb[0]; down1 = deb[0] & ~deb[A].
  - up2 = deb[8] & ~deb[7]; down2 = deb[7] & ~deb[8].
  - Opposing keys held together give 0 on both outputs.
- Any other keys (1-6, 9, B-F) affect only key_valid/key_code.

## Timing
- Reset (async assert, any state):
  - kp_row = 4'b1110; state SETTLE with counter 0.
  - All debounced states 0 and debounce counters 0; synchronizer flops 1 (released).
  - up1/down1/up2/down2 = 0; key_valid = 0; key_code = 4'h0.
- After reset release, the first SAMPLE (row 1110) occurs in cycle SETTLE_CYCLES, counting from 0.
- All outputs are registered. Debounced state, paddle outputs and key_valid change at the edge ending the SAMPLE cycle.
- kp_row changes at that same edge.
- Press latency: a key stable-pressed before its row's first sample asserts its output after DEBOUNCE_SCANS samples of that row. The worst case is DEBOUNCE_SCANS frames plus one frame of phase.
- Release latency equals press latency.
- key_valid is never asserted on two consecutive cycles; at most one assertion per SAMPLE.
- Reset mid-debounce discards partial counts, and no event is generated.

## Structure
- Package keypad_pkg holds:
  - the row-drive constants (ROW0..ROW3 = 4'b1110/1101/1011/0111);
  - the key-code constants (KEY_0, KEY_7, KEY_8, KEY_A, …);
  - the 16-entry {row index, col index}→code map;
  - the paddle key assignments.
- Sub-module kp_debounce holds one key's debounced state and counter, with inputs sample_en and pressed and output state/rise. 16 instances are generated.
- The FSM, row rotation, synchronizer, event priority and paddle logic live in the top.

## Test plan
- Reset check: hold rst=0 with kp_col=0000 → kp_row=1110, all outputs 0; release rst → kp_row steps 1110→1101 after SETTLE_CYCLES+1 cycles, full rotation every 12 cycles.
- Single press, defaults: model key A pressed (col 0111 low only while kp_row=1101) → up1=1 and one key_valid with key_code=4'hA after the 2nd row-1101 sample; release → up1=0 two frames later, no key_valid.
- Bounce rejection: key 0 toggles each frame → down1 stays 0 and key_valid never pulses.
- Conflict: keys 8 and 7 both held → up2=0, down2=0; release 7 → up2=1 once key 7's debounce completes.
- Same-row simultaneous press: keys 7 and 0 (row 1110, cols 1110 and 0111) pressed together → single key_valid with key_code=4'h7, and down1 and down2 both 1.
- Async reset mid-operation: assert rst during row 1011 SETTLE with up1=1 → kp_row=1110 and up1=0 immediately; with A still held, up1 returns after 2 frames.
